gddr6_ca_encoder: RTL and testbench



---
 rtl/gddr6_pkg.sv | 57 +++++
 rtl/gddr6_ca_encoder_if.sv | 26 ++
 rtl/gddr6_cabi_enc.sv | 22 ++
 rtl/gddr6_ca_encoder.sv | 114 +++++++++++
 tb/tb_gddr6_ca_encoder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gddr6_pkg.sv
// Shared GDDR6 command/address definitions: command codes, CA word layout and helpers.
package gddr6_pkg;

    localparam int unsigned CA_W     = 11;
    localparam int unsigned CMD_W    = 5;
    localparam int unsigned BANK_W   = 4;
    localparam int unsigned COL_W    = 7;
    localparam int unsigned BG_W     = 2;
    localparam int unsigned NUM_BG   = 4;
    localparam int unsigned ZCNT_W   = 4;
    localparam int unsigned ZERO_MAX = 5;

    localparam int unsigned TCCD_S_DEF = 2;
    localparam int unsigned TCCD_L_DEF = 4;

    localparam logic [CMD_W-1:0] CMD_NOP = 5'b00000;
    localparam logic [CMD_W-1:0] CMD_ACT = 5'b00100;
    localparam logic [CMD_W-1:0] CMD_RD  = 5'b00101;
    localparam logic [CMD_W-1:0] CMD_RDA = 5'b00110;

    localparam logic [CA_W-1:0] NOP_WORD = 11'h7FF;

    // CA field positions; fixed bits live in the base words below
    localparam int unsigned RISE_COL_LSB  = 0;
    localparam int unsigned RISE_BANK_LSB = 4;
    localparam int unsigned FALL_COLH_LSB = 0;
    localparam int unsigned FALL_AP_BIT   = 4;
    localparam logic [CA_W-1:0] RISE_BASE = 11'b111_0000_0000;
    localparam logic [CA_W-1:0] FALL_BASE = 11'b101_1110_1000;

    typedef struct packed {
        logic [CMD_W-1:0]  ctype;
        logic [BANK_W-1:0] bank;
        logic [COL_W-1:0]  col;
    } cmd_t;

    function automatic logic is_read(input logic [CMD_W-1:0] code);
        return (code == CMD_RD) || (code == CMD_RDA);
    endfunction

    function automatic logic [CA_W-1:0] rise_word(input cmd_t c);
        logic [CA_W-1:0] w;
        w = RISE_BASE;
        w[RISE_BANK_LSB +: BANK_W] = c.bank;
        w[RISE_COL_LSB +: 4]       = c.col[3:0];
        return w;
    endfunction

    function automatic logic [CA_W-1:0] fall_word(input cmd_t c);
        logic [CA_W-1:0] w;
        w = FALL_BASE;
        w[FALL_AP_BIT]         = (c.ctype == CMD_RDA);
        w[FALL_COLH_LSB +: 3]  = c.col[6:4];
        return w;
    endfunction

endpackage

// File: rtl/gddr6_ca_encoder_if.sv
// Request handshake and CA output bundle of the GDDR6 CA encoder.
interface gddr6_ca_encoder_if;
    import gddr6_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_type;
    logic [BANK_W-1:0] cmd_bank;
    logic [COL_W-1:0]  cmd_col;
    logic [CA_W-1:0]   ca_rise;
    logic [CA_W-1:0]   ca_fall;
    logic              cabi_rise_n;
    logic              cabi_fall_n;
    logic              ca_valid;
    logic              cmd_err;

    modport master (
        output cmd_valid, cmd_type, cmd_bank, cmd_col,
        input  cmd_ready, ca_rise, ca_fall, cabi_rise_n, cabi_fall_n, ca_valid, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_bank, cmd_col,
        output cmd_ready, ca_rise, ca_fall, cabi_rise_n, cabi_fall_n, ca_valid, cmd_err
    );
endinterface

// File: rtl/gddr6_cabi_enc.sv
// CA bus inversion: invert an 11-bit word when it carries more than ZERO_MAX zeros.
module gddr6_cabi_enc
    import gddr6_pkg::*;
(
    input  logic [CA_W-1:0] word_in,
    output logic [CA_W-1:0] word_out,
    output logic            inv_n
);
    logic [ZCNT_W-1:0] zeros;
    logic              inv;

    always_comb begin
        zeros = '0;
        for (int i = 0; i < CA_W; i++) begin
            zeros = zeros + ZCNT_W'(~word_in[i]);
        end
    end

    assign inv      = (zeros > ZCNT_W'(ZERO_MAX));
    assign word_out = inv ? ~word_in : word_in;
    assign inv_n    = ~inv;
endmodule

// File: rtl/gddr6_ca_encoder.sv
// GDDR6 read-command CA encoder with tCCD_S/tCCD_L spacing and a one-entry holding register.
// Optional CA bus inversion is enabled by defining GDDR6_CABI_EN.
module gddr6_ca_encoder
    import gddr6_pkg::*;
#(
    parameter int unsigned TCCD_S = TCCD_S_DEF,
    parameter int unsigned TCCD_L = TCCD_L_DEF,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              CLK_t,
    input  logic              RESET,
    input  logic              bg_en,
    gddr6_ca_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PEND, ISSUE} state_e;

    state_e          state_q, state_d;
    cmd_t            hold_q, hold_d, req;
    logic            hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] bgcnt_q [NUM_BG];
    logic [CNT_W-1:0] bgcnt_d [NUM_BG];
    logic [CA_W-1:0] rise_q, fall_q, rise_raw, fall_raw, rise_enc, fall_enc;
    logic            rise_inv_n, fall_inv_n, cabi_rise_n_q, cabi_fall_n_q;
    logic            cmd_err_q, cmd_err_d;
    logic [BG_W-1:0] hold_bg;
    logic            issue_now, ready, accept;

    assign req     = '{ctype: bus.cmd_type, bank: bus.cmd_bank, col: bus.cmd_col};
    assign hold_bg = hold_q.bank[3:2];

    // bg_en is used live so a change while pending takes effect at once
    assign issue_now = hold_valid_q && (gcnt_q >= CNT_W'(TCCD_S)) &&
                       (!bg_en || (bgcnt_q[hold_bg] >= CNT_W'(TCCD_L)));
    assign ready     = !RESET && (!hold_valid_q || issue_now);
    assign accept    = bus.cmd_valid && ready;

    assign rise_raw = issue_now ? rise_word(hold_q) : NOP_WORD;
    assign fall_raw = issue_now ? fall_word(hold_q) : NOP_WORD;

`ifdef GDDR6_CABI_EN
    gddr6_cabi_enc u_cabi_rise (.word_in(rise_raw), .word_out(rise_enc), .inv_n(rise_inv_n));
    gddr6_cabi_enc u_cabi_fall (.word_in(fall_raw), .word_out(fall_enc), .inv_n(fall_inv_n));
`else
    assign rise_enc   = rise_raw;
    assign fall_enc   = fall_raw;
    assign rise_inv_n = 1'b1;
    assign fall_inv_n = 1'b1;
`endif

    // Next state, holding register and spacing counters
    always_comb begin
        state_d      = IDLE;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cmd_err_d    = 1'b0;
        gcnt_d       = (gcnt_q >= CNT_W'(TCCD_L)) ? gcnt_q : gcnt_q + CNT_W'(1);
        for (int unsigned b = 0; b < NUM_BG; b++) begin
            bgcnt_d[b] = (bgcnt_q[b] >= CNT_W'(TCCD_L)) ? bgcnt_q[b] : bgcnt_q[b] + CNT_W'(1);
        end
        if (issue_now) begin
            gcnt_d           = CNT_W'(1);
            bgcnt_d[hold_bg] = CNT_W'(1);
            hold_valid_d     = 1'b0;
        end
        if (accept) begin
            if (is_read(bus.cmd_type)) begin
                hold_d       = req;
                hold_valid_d = 1'b1;
            end else begin
                cmd_err_d = 1'b1;
            end
        end
        if (issue_now) begin
            state_d = ISSUE;
        end else if (hold_valid_d) begin
            state_d = PEND;
        end
    end

    always_ff @(posedge CLK_t) begin
        if (RESET) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            gcnt_q        <= CNT_W'(TCCD_L);
            for (int unsigned b = 0; b < NUM_BG; b++) bgcnt_q[b] <= CNT_W'(TCCD_L);
            rise_q        <= NOP_WORD;
            fall_q        <= NOP_WORD;
            cabi_rise_n_q <= 1'b1;
            cabi_fall_n_q <= 1'b1;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            gcnt_q        <= gcnt_d;
            for (int unsigned b = 0; b < NUM_BG; b++) bgcnt_q[b] <= bgcnt_d[b];
            rise_q        <= rise_enc;
            fall_q        <= fall_enc;
            cabi_rise_n_q <= rise_inv_n;
            cabi_fall_n_q <= fall_inv_n;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign bus.cmd_ready   = ready;
    assign bus.ca_rise     = rise_q;
    assign bus.ca_fall     = fall_q;
    assign bus.cabi_rise_n = cabi_rise_n_q;
    assign bus.cabi_fall_n = cabi_fall_n_q;
    assign bus.ca_valid    = (state_q == ISSUE);
    assign bus.cmd_err     = cmd_err_q;
endmodule

// File: tb/tb_gddr6_ca_encoder.sv
// Directed self-checking bench for gddr6_ca_encoder (default and GDDR6_CABI_EN builds).
module tb_gddr6_ca_encoder;
    import gddr6_pkg::*;

    logic CLK_t = 1'b0;
    logic RESET = 1'b1;
    logic bg_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    gddr6_ca_encoder_if bus ();

    gddr6_ca_encoder dut (.CLK_t(CLK_t), .RESET(RESET), .bg_en(bg_en), .bus(bus));

    always #5 CLK_t = ~CLK_t;

`ifdef GDDR6_CABI_EN
    localparam logic [10:0] EXP_R0  = 11'h0FF;
    localparam logic        EXP_R0N = 1'b0;
`else
    localparam logic [10:0] EXP_R0  = 11'h700;
    localparam logic        EXP_R0N = 1'b1;
`endif

    task automatic tick();
        @(posedge CLK_t);
        #1;
    endtask

    task automatic present(input logic [4:0] t, input logic [3:0] b, input logic [6:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_bank  = b;
        bus.cmd_col   = c;
    endtask

    // Send A then B back to back; report issue times (edges after A's acceptance) and words
    task automatic run_pair(input logic [4:0] at, input logic [3:0] ab, input logic [6:0] ac,
                            input logic [4:0] bt, input logic [3:0] bb, input logic [6:0] bc,
                            input logic be, output int t1, output int t2,
                            output logic [10:0] r1, output logic [10:0] f1, output logic r1n,
                            output logic [10:0] r2, output logic [10:0] f2, output logic rdy2);
        logic rdy;
        logic b_pending;
        bg_en = be;
        for (int i = 0; i < 6; i++) tick();
        present(at, ab, ac);
        tick();
        present(bt, bb, bc);
        b_pending = 1'b1;
        t1 = -1; t2 = -1; rdy2 = 1'bx;
        r1 = '0; f1 = '0; r1n = 1'bx; r2 = '0; f2 = '0;
        for (int t = 1; t <= 20; t++) begin
            rdy = bus.cmd_ready;
            tick();
            if (b_pending && rdy) begin
                bus.cmd_valid = 1'b0;
                b_pending = 1'b0;
            end
            if (t == 2) rdy2 = bus.cmd_ready;
            if (bus.ca_valid === 1'b1) begin
                if (t1 < 0) begin
                    t1 = t; r1 = bus.ca_rise; f1 = bus.ca_fall; r1n = bus.cabi_rise_n;
                end else if (t2 < 0) begin
                    t2 = t; r2 = bus.ca_rise; f2 = bus.ca_fall;
                end
            end
            if (t2 >= 0) break;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        present(CMD_RD, 4'd0, 7'd0);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.ca_rise !== 11'h7FF || bus.ca_fall !== 11'h7FF || bus.cabi_rise_n !== 1'b1 ||
                bus.cabi_fall_n !== 1'b1 || bus.ca_valid !== 1'b0 || bus.cmd_ready !== 1'b0 ||
                bus.cmd_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: rise=%h fall=%h cabi=%b%b valid=%b ready=%b err=%b, want 7ff 7ff 11 0 0 0",
                         i, bus.ca_rise, bus.ca_fall, bus.cabi_rise_n, bus.cabi_fall_n,
                         bus.ca_valid, bus.cmd_ready, bus.cmd_err);
            end
        end
        bus.cmd_valid = 1'b0;
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_diff_bg();
        int t1, t2; logic [10:0] r1, f1, r2, f2; logic r1n, rdy2;
        run_pair(CMD_RD, 4'd0, 7'h00, CMD_RD, 4'd4, 7'h15, 1'b1, t1, t2, r1, f1, r1n, r2, f2, rdy2);
        checks++;
        if (t1 !== 1) begin errors++; $display("FAIL diff_bg_first_latency: got %0d want 1", t1); end
        checks++;
        if (t2 - t1 !== 2) begin errors++; $display("FAIL diff_bg_gap: got %0d want 2", t2 - t1); end
        checks++;
        if (r1 !== EXP_R0 || r1n !== EXP_R0N) begin
            errors++; $display("FAIL rd_b0_rise: got %h/%b want %h/%b", r1, r1n, EXP_R0, EXP_R0N);
        end
        checks++;
        if (f1 !== 11'h5E8) begin errors++; $display("FAIL rd_b0_fall: got %h want 5e8", f1); end
        checks++;
        if (r2 !== 11'h745 || f2 !== 11'h5E9) begin
            errors++; $display("FAIL diff_bg_words: got %h %h want 745 5e9", r2, f2);
        end
    endtask

    task automatic test_same_bg();
        int t1, t2; logic [10:0] r1, f1, r2, f2; logic r1n, rdy2;
        run_pair(CMD_RD, 4'd0, 7'h00, CMD_RD, 4'd1, 7'h2A, 1'b1, t1, t2, r1, f1, r1n, r2, f2, rdy2);
        checks++;
        if (t2 - t1 !== 4) begin errors++; $display("FAIL same_bg_gap: got %0d want 4", t2 - t1); end
        checks++;
        if (rdy2 !== 1'b0) begin errors++; $display("FAIL ready_while_pend: got %b want 0", rdy2); end
        checks++;
        if (r2 !== 11'h71A || f2 !== 11'h5EA) begin
            errors++; $display("FAIL same_bg_words: got %h %h want 71a 5ea", r2, f2);
        end
        run_pair(CMD_RD, 4'd0, 7'h00, CMD_RDA, 4'd1, 7'h2A, 1'b0, t1, t2, r1, f1, r1n, r2, f2, rdy2);
        checks++;
        if (t2 - t1 !== 2) begin errors++; $display("FAIL bg_off_gap: got %0d want 2", t2 - t1); end
        checks++;
        if (rdy2 !== 1'b1) begin errors++; $display("FAIL bg_off_ready: got %b want 1", rdy2); end
        checks++;
        if (r2 !== 11'h71A || f2 !== 11'h5FA) begin
            errors++; $display("FAIL rda_words: got %h %h want 71a 5fa", r2, f2);
        end
    endtask

    task automatic test_unsupported();
        logic rdy;
        logic seen;
        bg_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        present(CMD_ACT, 4'd2, 7'h11);
        rdy = bus.cmd_ready;
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL act_ready: got %b want 1", rdy); end
        checks++;
        if (bus.cmd_err !== 1'b1 || bus.ca_valid !== 1'b0 || bus.ca_rise !== 11'h7FF) begin
            errors++;
            $display("FAIL act_err_pulse: err=%b valid=%b rise=%h want 1 0 7ff",
                     bus.cmd_err, bus.ca_valid, bus.ca_rise);
        end
        tick();
        checks++;
        if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL act_err_width: got %b want 0", bus.cmd_err); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.ca_valid !== 1'b0 || bus.ca_fall !== 11'h7FF) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL act_not_held: got issue=%b want 0", seen); end
    endtask

    task automatic test_reset_mid_pend();
        logic seen;
        bg_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        present(CMD_RD, 4'd0, 7'h00);
        tick();
        present(CMD_RD, 4'd1, 7'h2A);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.ca_valid !== 1'b1) begin errors++; $display("FAIL rst_pend_first_issue: got %b want 1", bus.ca_valid); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.ca_valid !== 1'b0 || bus.cmd_err !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.ca_rise !== 11'h7FF) begin
            errors++;
            $display("FAIL rst_pend_cleared: valid=%b err=%b ready=%b rise=%h want 0 0 1 7ff",
                     bus.ca_valid, bus.cmd_err, bus.cmd_ready, bus.ca_rise);
        end
        present(CMD_RD, 4'd1, 7'h15);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.ca_valid !== 1'b0) begin errors++; $display("FAIL rst_pend_latency: got %b want 0", bus.ca_valid); end
        tick();
        checks++;
        if (bus.ca_valid !== 1'b1 || bus.ca_rise !== 11'h715 || bus.ca_fall !== 11'h5E9) begin
            errors++;
            $display("FAIL rst_pend_no_spacing: valid=%b rise=%h fall=%h want 1 715 5e9",
                     bus.ca_valid, bus.ca_rise, bus.ca_fall);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.ca_valid !== 1'b0 || bus.cmd_err !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_pend_discard: got activity=%b want 0", seen); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = CMD_NOP;
        bus.cmd_bank  = '0;
        bus.cmd_col   = '0;
        test_reset();
        test_diff_bg();
        test_same_bg();
        test_unsupported();
        test_reset_mid_pend();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
